mod_fixup_serializer: RTL and testbench

Transmit-side counterpart of the single-bit `fs_*` serial path used by the fixup user/target hierarchy. Accepts parallel words on a valid/ready handshake and emits each word as a framed serial bit stream on one output line. That line is intended to drive an `fs_in`-style input of a downstream receiver. Frames are start bit, data bits LSB first, optional parity bit, then stop bit, each held for a fixed number of clocks.

---
 rtl/fixup_pkg.sv | 19 +
 rtl/mod_fixup_bit_timer.sv | 29 ++
 rtl/mod_fixup_serializer.sv | 125 ++++++++++++
 tb/tb_mod_fixup_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixup_pkg.sv
// Shared types and line levels for the fixup serial transmit path.
// Optional feature macro: FIXUP_PARITY_EN (adds the even-parity state).
package fixup_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef FIXUP_PARITY_EN
    StParity,
`endif
    StStop
  } fixup_tx_state_t;

  localparam logic FIXUP_IDLE_LEVEL  = 1'b1;
  localparam logic FIXUP_START_LEVEL = 1'b0;
  localparam logic FIXUP_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/mod_fixup_bit_timer.sv
// Per-bit cycle timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module mod_fixup_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;

  // Count cycles within a bit; wrap on the last cycle so consecutive bits restart at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign tick = (r_cnt == LastCnt);

endmodule

// File: rtl/mod_fixup_serializer.sv
// Parallel-to-serial framer: start bit, data LSB first, optional even parity, stop bit.
// Optional feature macro: FIXUP_PARITY_EN (inserts one even-parity bit before stop).
import fixup_pkg::*;

module mod_fixup_serializer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              fs_out,
  output logic              fs_busy,
  output logic              fs_done
);

  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  fixup_tx_state_t   r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IdxW-1:0]   r_idx;
  logic              r_fs_out;
`ifdef FIXUP_PARITY_EN
  logic              r_parity;
`endif

  logic              w_tick;
  logic              w_hs;
  logic              w_timer_clear;
  logic [DATA_W-1:0] w_shift_nxt;

  // Timer is held at zero while idle, so it starts fresh with the start bit; every later
  // state change coincides with its wrap.
  assign w_timer_clear = (r_state == StIdle);

  mod_fixup_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(w_timer_clear),
    .tick (w_tick)
  );

  assign tx_ready    = (r_state == StIdle) && !rst;
  assign w_hs        = tx_valid && tx_ready;
  assign w_shift_nxt = r_shift >> 1;

  // Frame FSM; fs_out is loaded with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_idx    <= '0;
      r_fs_out <= FIXUP_IDLE_LEVEL;
`ifdef FIXUP_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_hs) begin
            r_state  <= StStart;
            r_shift  <= tx_data;
            r_fs_out <= FIXUP_START_LEVEL;
`ifdef FIXUP_PARITY_EN
            r_parity <= ^tx_data;
`endif
          end
        end
        StStart: begin
          if (w_tick) begin
            r_state  <= StData;
            r_idx    <= '0;
            r_fs_out <= r_shift[0];
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_idx == LastIdx) begin
`ifdef FIXUP_PARITY_EN
              r_state  <= StParity;
              r_fs_out <= r_parity;
`else
              r_state  <= StStop;
              r_fs_out <= FIXUP_STOP_LEVEL;
`endif
            end else begin
              r_shift  <= w_shift_nxt;
              r_idx    <= r_idx + IdxW'(1);
              r_fs_out <= w_shift_nxt[0];
            end
          end
        end
`ifdef FIXUP_PARITY_EN
        StParity: begin
          if (w_tick) begin
            r_state  <= StStop;
            r_fs_out <= FIXUP_STOP_LEVEL;
          end
        end
`endif
        StStop: begin
          if (w_tick) begin
            r_state  <= StIdle;
            r_fs_out <= FIXUP_IDLE_LEVEL;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_fs_out <= FIXUP_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign fs_out  = r_fs_out;
  assign fs_busy = (r_state != StIdle);
  // Last cycle of the stop bit; decoded from registered state and timer.
  assign fs_done = (r_state == StStop) && w_tick;

endmodule

// File: tb/tb_mod_fixup_serializer.sv
// Self-checking bench: two serializers (4 and 1 clocks per bit) against a queue-based
// frame model, plus directed frames with hand-computed bit patterns.
module tb_mod_fixup_serializer;

  localparam int unsigned DW    = 8;
  localparam int unsigned CPB_A = 4;
  localparam int unsigned CPB_B = 1;
`ifdef FIXUP_PARITY_EN
  localparam int unsigned NB = DW + 3;
  localparam logic [15:0] ExpA5 = 16'h054A;
  localparam logic [15:0] Exp07 = 16'h060E;
  localparam logic [15:0] Exp12 = 16'h0424;
  localparam int FrameA = 44;
  localparam int FrameB = 11;
`else
  localparam int unsigned NB = DW + 2;
  localparam logic [15:0] ExpA5 = 16'h034A;
  localparam logic [15:0] Exp07 = 16'h020E;
  localparam logic [15:0] Exp12 = 16'h0224;
  localparam int FrameA = 40;
  localparam int FrameB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst = 1'b1, a_valid = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready, a_out, a_busy, a_done;
  logic          b_rst = 1'b1, b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready, b_out, b_busy, b_done;

  int total = 0;
  int bad   = 0;

  // Expected line level for each upcoming cycle of the frame in flight.
  bit qa[$];
  bit qb[$];

  mod_fixup_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB_A)) u_dut_a (
    .clk     (clk),
    .rst     (a_rst),
    .tx_data (a_data),
    .tx_valid(a_valid),
    .tx_ready(a_ready),
    .fs_out  (a_out),
    .fs_busy (a_busy),
    .fs_done (a_done)
  );

  mod_fixup_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB_B)) u_dut_b (
    .clk     (clk),
    .rst     (b_rst),
    .tx_data (b_data),
    .tx_valid(b_valid),
    .tx_ready(b_ready),
    .fs_out  (b_out),
    .fs_busy (b_busy),
    .fs_done (b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame levels in transmission order, bit 0 first.
  function automatic logic [15:0] frame_bits(input logic [DW-1:0] w);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < int'(DW); i++) f[1+i] = w[i];
`ifdef FIXUP_PARITY_EN
    f[DW+1] = ^w;
    f[DW+2] = 1'b1;
`else
    f[DW+1] = 1'b1;
`endif
    return f;
  endfunction

  // Model: a word is accepted only when the model is idle and not in reset.
  always @(posedge clk) begin
    logic [15:0] fb;
    bit idle_a, idle_b;
    idle_a = (qa.size() == 0);
    if (!idle_a) void'(qa.pop_front());
    if (a_rst) qa.delete();
    else if (idle_a && a_valid) begin
      fb = frame_bits(a_data);
      for (int i = 0; i < int'(NB); i++)
        for (int k = 0; k < int'(CPB_A); k++) qa.push_back(fb[i]);
    end
    idle_b = (qb.size() == 0);
    if (!idle_b) void'(qb.pop_front());
    if (b_rst) qb.delete();
    else if (idle_b && b_valid) begin
      fb = frame_bits(b_data);
      for (int i = 0; i < int'(NB); i++)
        for (int k = 0; k < int'(CPB_B); k++) qb.push_back(fb[i]);
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    chk("a_fs_out",   a_out,   (qa.size() != 0) ? qa[0] : 1'b1);
    chk("a_fs_busy",  a_busy,  qa.size() != 0);
    chk("a_fs_done",  a_done,  qa.size() == 1);
    chk("a_tx_ready", a_ready, (qa.size() == 0) && !a_rst);
    chk("b_fs_out",   b_out,   (qb.size() != 0) ? qb[0] : 1'b1);
    chk("b_fs_busy",  b_busy,  qb.size() != 0);
    chk("b_fs_done",  b_done,  qb.size() == 1);
    chk("b_tx_ready", b_ready, (qb.size() == 0) && !b_rst);
  end

  task automatic send_capture(input bit sel, input logic [DW-1:0] w,
                              output logic [15:0] bits, output int nbusy, output int ndone);
    int cpb;
    int c;
    cpb   = sel ? int'(CPB_B) : int'(CPB_A);
    bits  = '0;
    nbusy = 0;
    ndone = 0;
    c     = 0;
    @(posedge clk); #1;
    if (sel) begin b_valid = 1'b1; b_data = w; end
    else     begin a_valid = 1'b1; a_data = w; end
    @(posedge clk); #1;
    // Scramble the input after the handshake; the frame must not change.
    if (sel) begin b_valid = 1'b0; b_data = ~w; end
    else     begin a_valid = 1'b0; a_data = ~w; end
    while (c < 400) begin
      @(negedge clk);
      if (!(sel ? b_busy : a_busy)) break;
      if ((c % cpb) == 0 && (c / cpb) < 16) bits[c/cpb] = sel ? b_out : a_out;
      nbusy++;
      if (sel ? b_done : a_done) ndone++;
      c++;
    end
    if (c >= 400) chk("capture_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input bit sel);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((sel ? b_busy : a_busy) && c < 400);
    if (c >= 400) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [15:0] bits;
    int nb, nd, c, dc, sc;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", a_ready, 1'b1);
    chk("b_ready_after_rst", b_ready, 1'b1);
    chk("a_out_after_rst",   a_out,   1'b1);

    // Single frames with literal bit patterns.
    send_capture(1'b0, 8'hA5, bits, nb, nd);
    chk("a5_bits", bits, ExpA5);
    chk("a5_len", nb, FrameA);
    chk("a5_done_cnt", nd, 1);
    send_capture(1'b0, 8'h07, bits, nb, nd);
    chk("07_bits", bits, Exp07);
    chk("07_len", nb, FrameA);

    // Back-to-back with valid held high.
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = 8'h3C;
    @(posedge clk); #1;
    a_data = 8'hC3;
    c = 0; dc = -1; sc = -1;
    while (c < 400 && sc < 0) begin
      @(negedge clk);
      if (a_done) dc = c;
      else if (dc >= 0 && a_out == 1'b0) sc = c;
      c++;
    end
    a_valid = 1'b0;
    chk("b2b_gap", sc - dc, 2);
    wait_idle(1'b0);

    // Valid pulsed while busy must be ignored.
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = 8'h5A;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    a_valid = 1'b1;
    a_data  = 8'hFF;
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_idle(1'b0);
    repeat (5) @(negedge clk);
    chk("ignore_busy", a_busy, 1'b0);

    // Reset during data bit 3 of 0x55 (a zero bit).
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = 8'h55;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(negedge clk);
    chk("abort_out", a_out, 1'b1);
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_done", a_done, 1'b0);
    send_capture(1'b0, 8'h12, bits, nb, nd);
    chk("12_bits", bits, Exp12);

    // One clock per bit.
    send_capture(1'b1, 8'h12, bits, nb, nd);
    chk("b12_bits", bits, Exp12);
    chk("b12_len", nb, FrameB);
    chk("b12_done_cnt", nd, 1);
    send_capture(1'b1, 8'hA5, bits, nb, nd);
    chk("ba5_bits", bits, ExpA5);

    // Random traffic with occasional resets on both DUTs.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      a_valid = ($urandom_range(0, 3) == 0);
      a_data  = DW'($urandom);
      a_rst   = ($urandom_range(0, 199) == 0);
      b_valid = ($urandom_range(0, 2) == 0);
      b_data  = DW'($urandom);
      b_rst   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_rst   = 1'b0;
    b_valid = 1'b0;
    b_rst   = 1'b0;
    wait_idle(1'b0);
    wait_idle(1'b1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
